// File: rtl/tuser_pkg.sv
// Shared widths, FSM state encoding and beat-record sizing for the tuser ingress stage.
package tuser_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 256;
    localparam int unsigned DEFAULT_KEEP_WIDTH  = DEFAULT_DATA_WIDTH / 8;
    localparam int unsigned DEFAULT_TUSER_WIDTH = 128;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'b01,
        IN_PKT   = 2'b10
    } state_e;

    // Beat record layout: {sop, tuser, tlast, keep, data}
    function automatic int unsigned beat_width(input int unsigned dw, input int unsigned kw,
                                               input int unsigned tw);
        return dw + kw + 1 + tw + 1;
    endfunction

    localparam int unsigned BEAT_WIDTH =
        beat_width(DEFAULT_DATA_WIDTH, DEFAULT_KEEP_WIDTH, DEFAULT_TUSER_WIDTH);

endpackage

// File: rtl/tuser_in_fsm_axis_skid_buf.sv
// Two-entry registered valid/ready slice: output register plus skid register, ready is registered.
module axis_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q, ready_d;
    logic         in_fire;
    logic         load;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = in_valid & ready_q;
        load         = ~out_valid_q | out_ready;

        if (load) begin
            if (skid_valid_q) begin
                // Oldest beat sits in the skid; a new beat queues behind it.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_fire;
                if (in_fire) skid_data_d = in_data;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_data_d = in_data;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/tuser_in_fsm.sv
// AXIS ingress stage: strips tuser from the stream and presents the SOP-beat tuser as a tuple.
module tuser_in_fsm
    import tuser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned TUSER_WIDTH = DEFAULT_TUSER_WIDTH
) (
    input  logic                   tin_aclk,
    input  logic                   tin_arstn,
    input  logic                   tin_avalid,
    output logic                   tin_aready,
    input  logic [DATA_WIDTH-1:0]  tin_adata,
    input  logic [KEEP_WIDTH-1:0]  tin_akeep,
    input  logic                   tin_atlast,
    input  logic [TUSER_WIDTH-1:0] tin_atuser,
    output logic                   tin_bvalid,
    input  logic                   tin_bready,
    output logic [DATA_WIDTH-1:0]  tin_bdata,
    output logic [KEEP_WIDTH-1:0]  tin_bkeep,
    output logic                   tin_btlast,
    output logic                   tin_tvalid,
    output logic [TUSER_WIDTH-1:0] tin_tdata,
    output logic [1:0]             dbg_state,
    output logic [31:0]            dbg_pkt_cnt
);

    localparam int unsigned BW       = beat_width(DATA_WIDTH, KEEP_WIDTH, TUSER_WIDTH);
    localparam int unsigned KeepLsb  = DATA_WIDTH;
    localparam int unsigned LastBit  = DATA_WIDTH + KEEP_WIDTH;
    localparam int unsigned TuserLsb = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int unsigned SopBit   = BW - 1;

    state_e                 state_q, state_d;
    logic                   accept;
    logic                   b_fire;
    logic [BW-1:0]          in_beat;
    logic [BW-1:0]          out_beat;
    logic [TUSER_WIDTH-1:0] tdata_q;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;

    assign accept  = tin_avalid & tin_aready;
    assign in_beat = {(state_q == WAIT_SOP), tin_atuser, tin_atlast, tin_akeep, tin_adata};

    always_comb begin
        state_d = state_q;
        if (accept) state_d = tin_atlast ? WAIT_SOP : IN_PKT;
    end

    always_ff @(posedge tin_aclk) begin
        if (!tin_arstn) state_q <= WAIT_SOP;
        else            state_q <= state_d;
    end

    axis_skid_buf #(
        .W(BW)
    ) u_skid (
        .clk      (tin_aclk),
        .rst_n    (tin_arstn),
        .in_valid (tin_avalid),
        .in_ready (tin_aready),
        .in_data  (in_beat),
        .out_valid(tin_bvalid),
        .out_ready(tin_bready),
        .out_data (out_beat)
    );

    always_comb begin
        tin_bdata  = out_beat[DATA_WIDTH-1:0];
        tin_bkeep  = out_beat[KeepLsb +: KEEP_WIDTH];
        tin_btlast = out_beat[LastBit];
        b_fire     = tin_bvalid & tin_bready;
        tin_tvalid = b_fire & out_beat[SopBit];
        // Tuple data follows the SOP beat in the cycle it leaves, then holds.
        tin_tdata  = tin_tvalid ? out_beat[TuserLsb +: TUSER_WIDTH] : tdata_q;
        pkt_cnt_d  = pkt_cnt_q + {31'd0, b_fire & tin_btlast};
    end

    always_ff @(posedge tin_aclk) begin
        if (!tin_arstn) begin
            tdata_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            tdata_q   <= tin_tdata;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign dbg_state   = state_q;
    assign dbg_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Scoreboard bench for tuser_in_fsm: driver queues expected beats, a negedge monitor checks them.
module tb_tuser_in_fsm;

    localparam int unsigned DW = 256;
    localparam int unsigned KW = 32;
    localparam int unsigned TW = 128;

    logic          clk = 1'b0;
    logic          tin_arstn;
    logic          tin_avalid;
    logic          tin_aready;
    logic [DW-1:0] tin_adata;
    logic [KW-1:0] tin_akeep;
    logic          tin_atlast;
    logic [TW-1:0] tin_atuser;
    logic          tin_bvalid;
    logic          tin_bready;
    logic [DW-1:0] tin_bdata;
    logic [KW-1:0] tin_bkeep;
    logic          tin_btlast;
    logic          tin_tvalid;
    logic [TW-1:0] tin_tdata;
    logic [1:0]    dbg_state;
    logic [31:0]   dbg_pkt_cnt;

    always #5 clk = ~clk;

    tuser_in_fsm dut (
        .tin_aclk   (clk),
        .tin_arstn  (tin_arstn),
        .tin_avalid (tin_avalid),
        .tin_aready (tin_aready),
        .tin_adata  (tin_adata),
        .tin_akeep  (tin_akeep),
        .tin_atlast (tin_atlast),
        .tin_atuser (tin_atuser),
        .tin_bvalid (tin_bvalid),
        .tin_bready (tin_bready),
        .tin_bdata  (tin_bdata),
        .tin_bkeep  (tin_bkeep),
        .tin_btlast (tin_btlast),
        .tin_tvalid (tin_tvalid),
        .tin_tdata  (tin_tdata),
        .dbg_state  (dbg_state),
        .dbg_pkt_cnt(dbg_pkt_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          sop;
        logic [TW-1:0] tuser;
        int            acc_cyc;
    } beat_t;

    beat_t         exp_q[$];
    int            tv_cyc[$];
    int            errors = 0;
    int            checks = 0;
    int            cycle = 0;
    int            bp_mode = 0;
    bit            lat_chk = 1'b0;
    bit            bp_done;
    logic [31:0]   model_cnt = '0;
    logic [TW-1:0] model_tdata = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_tuser();
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Sink ready: 0 = always ready, 1 = random, 2 = held off
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       tin_bready = 1'b1;
            1:       tin_bready = ($urandom_range(0, 3) != 0);
            default: tin_bready = 1'b0;
        endcase
    end

    // Monitor: B-side transfers against the scoreboard, tuple and counter against the model
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic [KW-1:0] held_keep;
    logic          held_last;

    always @(negedge clk) begin
        beat_t b;
        if (!tin_arstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_bvalid", tin_bvalid, 1'b1);
                check("stall_bdata", tin_bdata, held_data);
                check("stall_bkeep", tin_bkeep, held_keep);
                check("stall_btlast", tin_btlast, held_last);
            end
            stall_prev = tin_bvalid & ~tin_bready;
            held_data  = tin_bdata;
            held_keep  = tin_bkeep;
            held_last  = tin_btlast;

            if (tin_bvalid && tin_bready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    check("bdata", tin_bdata, b.data);
                    check("bkeep", tin_bkeep, b.keep);
                    check("btlast", tin_btlast, b.last);
                    check("tvalid", tin_tvalid, b.sop);
                    if (b.sop) model_tdata = b.tuser;
                    check("tdata", tin_tdata, model_tdata);
                    check("pkt_cnt", dbg_pkt_cnt, model_cnt);
                    if (lat_chk) check("latency", cycle - b.acc_cyc, 1);
                    if (b.last) model_cnt = model_cnt + 32'd1;
                    if (tin_tvalid) tv_cyc.push_back(cycle);
                end
            end else begin
                check("tvalid_idle", tin_tvalid, 1'b0);
                check("tdata_hold", tin_tdata, model_tdata);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic last, input logic sop, input logic [TW-1:0] tuser,
                             input int gap);
        beat_t b;
        int    waited = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom();
        b.keep     = $urandom();
        b.last     = last;
        b.sop      = sop;
        b.tuser    = tuser;
        tin_adata  = b.data;
        tin_akeep  = b.keep;
        tin_atlast = last;
        tin_atuser = tuser;
        tin_avalid = 1'b1;
        forever begin
            @(negedge clk);
            if (tin_aready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 1'b0, 1'b1);
                @(posedge clk);
                #1;
                tin_avalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        b.acc_cyc = cycle;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        tin_avalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [TW-1:0] tuser, input int maxgap);
        for (int i = 0; i < n; i++)
            send_beat(i == n - 1, i == 0, (i == 0) ? tuser : rand_tuser(),
                      $urandom_range(0, maxgap));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aready"}, tin_aready, 1'b0);
        check({tag, "_bvalid"}, tin_bvalid, 1'b0);
        check({tag, "_bdata"}, tin_bdata, '0);
        check({tag, "_bkeep"}, tin_bkeep, '0);
        check({tag, "_btlast"}, tin_btlast, 1'b0);
        check({tag, "_tvalid"}, tin_tvalid, 1'b0);
        check({tag, "_tdata"}, tin_tdata, '0);
        check({tag, "_pkt_cnt"}, dbg_pkt_cnt, '0);
        check({tag, "_state"}, dbg_state, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n0;
        logic [TW-1:0] tu;

        tin_arstn  = 1'b0;
        tin_avalid = 1'b1;
        tin_adata  = '0;
        tin_akeep  = '0;
        tin_atlast = 1'b0;
        tin_atuser = '0;
        tin_bready = 1'b0;

        // Reset held 3 cycles with avalid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        tin_arstn  = 1'b1;
        tin_avalid = 1'b0;
        @(negedge clk);
        check("aready_before_edge", tin_aready, 1'b0);
        check("no_accept_bvalid", tin_bvalid, 1'b0);
        @(negedge clk);
        check("aready_after_release", tin_aready, 1'b1);
        @(posedge clk);
        #1;

        // 3-beat packet
        lat_chk = 1'b1;
        n0 = tv_cyc.size();
        send_beat(1'b0, 1'b1, 128'd44444, 0);
        send_beat(1'b0, 1'b0, 128'd0, 0);
        send_beat(1'b1, 1'b0, 128'd0, 0);
        drain();
        @(negedge clk);
        check("three_beat_pulses", tv_cyc.size() - n0, 1);
        check("three_beat_tdata", tin_tdata, 128'd44444);
        check("three_beat_cnt", dbg_pkt_cnt, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-beat packets
        n0 = tv_cyc.size();
        send_pkt(1, 128'd1, 0);
        send_pkt(1, 128'd2, 0);
        send_pkt(1, 128'd3, 0);
        drain();
        check("b2b_pulses", tv_cyc.size() - n0, 3);
        if (tv_cyc.size() - n0 == 3) begin
            check("b2b_gap1", tv_cyc[n0+1] - tv_cyc[n0], 1);
            check("b2b_gap2", tv_cyc[n0+2] - tv_cyc[n0+1], 1);
        end
        check("b2b_cnt", dbg_pkt_cnt, 32'd4);
        lat_chk = 1'b0;

        // Backpressure: sink held off for 4 cycles mid-packet
        bp_mode = 2;
        @(posedge clk);
        #1;
        tu      = rand_tuser();
        bp_done = 1'b0;
        fork
            begin
                send_pkt(6, tu, 0);
                bp_done = 1'b1;
            end
        join_none
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_aready_low", tin_aready, 1'b0);
        check("bp_buffered", exp_q.size(), 2);
        check("bp_bvalid", tin_bvalid, 1'b1);
        bp_mode = 0;
        for (int i = 0; i < 500 && !bp_done; i++) @(posedge clk);
        check("bp_sender_done", bp_done, 1'b1);
        #1;
        drain();

        // Reset after beat 2 of 4 with both beats still buffered
        bp_mode = 2;
        @(posedge clk);
        #1;
        send_beat(1'b0, 1'b1, rand_tuser(), 0);
        send_beat(1'b0, 1'b0, rand_tuser(), 0);
        tin_arstn = 1'b0;
        exp_q.delete();
        model_cnt   = '0;
        model_tdata = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        tin_arstn = 1'b1;
        bp_mode   = 0;
        @(posedge clk);
        #1;
        n0 = tv_cyc.size();
        send_pkt(4, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0, 0);
        drain();
        check("midreset_pulse", tv_cyc.size() - n0, 1);
        check("midreset_tdata", tin_tdata, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);

        // Counter wrap from a preloaded all-ones value
        @(negedge clk);
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        check("preload_cnt", dbg_pkt_cnt, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        send_pkt(2, rand_tuser(), 0);
        drain();
        @(negedge clk);
        check("wrap_cnt", dbg_pkt_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random sink stalls and source gaps
        bp_mode = 1;
        for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 5), rand_tuser(), 2);
        bp_mode = 0;
        drain();
        @(negedge clk);
        check("final_cnt", dbg_pkt_cnt, model_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
